// File: rtl/console_key_fifo.sv
// Receive-side byte buffer for the virtio console: FIFO storage, batching FSM
// that raises a one-cycle request, and a budgeted FWFT pop port for the MCU.
module console_key_fifo #(
    parameter int DEPTH     = 64,
    parameter int MAX_BATCH = 16,
    parameter int HOLDOFF   = 1024
) (
    input  logic                         CLK,
    input  logic                         RST_X,
    input  logic                         w_rx_valid,
    input  logic [7:0]                   w_rx_data,
    output logic                         w_rx_ready,
    input  logic                         w_enable,
    input  logic                         w_mc_busy,
    output logic                         w_keyreq,
    output logic [$clog2(MAX_BATCH):0]   w_kcount,
    output logic [7:0]                   w_kdata,
    input  logic                         w_kpop,
    input  logic                         w_kdone,
    output logic [$clog2(DEPTH):0]       w_level,
    output logic                         w_overflow,
    input  logic                         w_ovf_clr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam int CNT_W = $clog2(MAX_BATCH) + 1;
    localparam int TMR_W = $clog2(HOLDOFF) + 1;

    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_BATCH = LVL_W'(MAX_BATCH);
    localparam logic [TMR_W-1:0] TMR_LOAD  = TMR_W'(HOLDOFF - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        REQ   = 2'd2,
        SERVE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [CNT_W-1:0]  budget_q, budget_d;
    logic [CNT_W-1:0]  kcount_q, kcount_d;
    logic              keyreq_q, keyreq_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              ovf_q, ovf_d;
    logic [7:0]        mem_q [DEPTH];

    logic              full;
    logic              push_ok;
    logic              drop;
    logic              pop_ok;
    logic [CNT_W-1:0]  batch;

    // Fullness is judged on the registered level, so a same-cycle pop never
    // makes room for a push.
    assign full    = (level_q == LVL_FULL);
    assign push_ok = w_rx_valid && !full;
    assign drop    = w_rx_valid && full;
    assign pop_ok  = (state_q == SERVE) && w_kpop && (budget_q != '0);
    assign batch   = (level_q >= LVL_BATCH) ? CNT_W'(MAX_BATCH) : CNT_W'(level_q);

    assign w_rx_ready = !full;
    assign w_level    = level_q;
    assign w_overflow = ovf_q;
    assign w_keyreq   = keyreq_q;
    assign w_kcount   = kcount_q;
    assign w_kdata    = (level_q == '0) ? 8'h00 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        if (drop) begin
            ovf_d = 1'b1;
        end else if (w_ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        budget_d = budget_q;
        kcount_d = kcount_q;
        keyreq_d = 1'b0;
        case (state_q)
            IDLE: begin
                if ((level_q != '0) && w_enable) begin
                    state_d = HOLD;
                    timer_d = TMR_LOAD;
                end
            end
            HOLD: begin
                timer_d = (timer_q == '0) ? '0 : timer_q - TMR_W'(1);
                if (!w_enable) begin
                    state_d = IDLE;
                end else if (((level_q >= LVL_BATCH) || (timer_q == '0)) && !w_mc_busy) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                // The pulse is registered so it appears together with the
                // latched byte count.
                keyreq_d = 1'b1;
                kcount_d = batch;
                budget_d = batch;
                state_d  = SERVE;
            end
            SERVE: begin
                if (pop_ok) begin
                    budget_d = budget_q - CNT_W'(1);
                end
                if (w_kdone) begin
                    state_d  = IDLE;
                    kcount_d = '0;
                    budget_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            budget_q <= '0;
            kcount_q <= '0;
            keyreq_q <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            budget_q <= budget_d;
            kcount_q <= kcount_d;
            keyreq_q <= keyreq_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= w_rx_data;
        end
    end

endmodule

// File: tb/tb_console_key_fifo.sv
// Scenario bench for console_key_fifo: byte scoreboard for FIFO order plus
// cycle-exact checks on request timing, batching, overflow and reset.
module tb_console_key_fifo;

    localparam int DEPTH     = 64;
    localparam int MAX_BATCH = 16;
    localparam int HOLDOFF   = 8;
    localparam int KC_W      = $clog2(MAX_BATCH) + 1;
    localparam int LVL_W     = $clog2(DEPTH) + 1;

    logic              CLK;
    logic              RST_X;
    logic              w_rx_valid;
    logic [7:0]        w_rx_data;
    logic              w_rx_ready;
    logic              w_enable;
    logic              w_mc_busy;
    logic              w_keyreq;
    logic [KC_W-1:0]   w_kcount;
    logic [7:0]        w_kdata;
    logic              w_kpop;
    logic              w_kdone;
    logic [LVL_W-1:0]  w_level;
    logic              w_overflow;
    logic              w_ovf_clr;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb[$];

    console_key_fifo #(
        .DEPTH    (DEPTH),
        .MAX_BATCH(MAX_BATCH),
        .HOLDOFF  (HOLDOFF)
    ) dut (
        .CLK       (CLK),
        .RST_X     (RST_X),
        .w_rx_valid(w_rx_valid),
        .w_rx_data (w_rx_data),
        .w_rx_ready(w_rx_ready),
        .w_enable  (w_enable),
        .w_mc_busy (w_mc_busy),
        .w_keyreq  (w_keyreq),
        .w_kcount  (w_kcount),
        .w_kdata   (w_kdata),
        .w_kpop    (w_kpop),
        .w_kdone   (w_kdone),
        .w_level   (w_level),
        .w_overflow(w_overflow),
        .w_ovf_clr (w_ovf_clr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST_X      = 1'b0;
        w_rx_valid = 1'b0;
        w_rx_data  = 8'h00;
        w_enable   = 1'b0;
        w_mc_busy  = 1'b0;
        w_kpop     = 1'b0;
        w_kdone    = 1'b0;
        w_ovf_clr  = 1'b0;
        sb.delete();
        tick();
        tick();
        #2;
        RST_X = 1'b1;
        tick();
    endtask

    task automatic push_byte(input logic [7:0] b);
        w_rx_valid = 1'b1;
        w_rx_data  = b;
        if (sb.size() < DEPTH) sb.push_back(b);
        tick();
        w_rx_valid = 1'b0;
    endtask

    task automatic pop_byte();
        logic [7:0] exp_b;
        exp_b = (sb.size() > 0) ? sb[0] : 8'hxx;
        checks++;
        if (sb.size() == 0 || w_kdata !== exp_b) begin
            errors++;
            $display("FAIL kdata: got %02h expected %02h (sb size %0d)", w_kdata, exp_b, sb.size());
        end
        w_kpop = 1'b1;
        tick();
        w_kpop = 1'b0;
        if (sb.size() > 0) void'(sb.pop_front());
    endtask

    task automatic wait_keyreq(input int max_cyc, output int n);
        bit found;
        found = 1'b0;
        n = 0;
        while (n < max_cyc && !found) begin
            tick();
            n++;
            if (w_keyreq === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL keyreq_timeout: no keyreq within %0d cycles", max_cyc);
        end
    endtask

    task automatic serve_batch(input int exp_cnt);
        int n;
        wait_keyreq(300, n);
        checks++;
        if (w_kcount !== KC_W'(exp_cnt)) begin
            errors++;
            $display("FAIL batch_kcount: got %0d expected %0d", w_kcount, exp_cnt);
        end
        for (int i = 0; i < exp_cnt; i++) begin
            pop_byte();
            if (i == 0) begin
                checks++;
                if (w_keyreq !== 1'b0) begin
                    errors++;
                    $display("FAIL keyreq_single_cycle: got %b expected 0", w_keyreq);
                end
            end
        end
        w_kdone = 1'b1;
        tick();
        w_kdone = 1'b0;
        checks++;
        if (w_kcount !== '0) begin
            errors++;
            $display("FAIL kcount_after_done: got %0d expected 0", w_kcount);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (w_keyreq !== 1'b0 || w_kcount !== '0 || w_level !== '0 ||
            w_overflow !== 1'b0 || w_rx_ready !== 1'b1 || w_kdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: keyreq=%b kcount=%0d level=%0d ovf=%b ready=%b kdata=%02h expected 0 0 0 0 1 00",
                     w_keyreq, w_kcount, w_level, w_overflow, w_rx_ready, w_kdata);
        end
    endtask

    task automatic test_single_byte();
        int n;
        do_reset();
        w_enable = 1'b1;
        push_byte(8'h41);
        wait_keyreq(50, n);
        checks++;
        if (n - 1 != HOLDOFF + 1) begin
            errors++;
            $display("FAIL single_latency: got %0d cycles after HOLD entry expected %0d", n - 1, HOLDOFF + 1);
        end
        checks++;
        if (w_kcount !== KC_W'(1)) begin
            errors++;
            $display("FAIL single_kcount: got %0d expected 1", w_kcount);
        end
        pop_byte();
        checks++;
        if (w_level !== '0) begin
            errors++;
            $display("FAIL single_level: got %0d expected 0", w_level);
        end
        w_kdone = 1'b1;
        tick();
        w_kdone = 1'b0;
        checks++;
        if (w_kcount !== '0) begin
            errors++;
            $display("FAIL single_kcount_done: got %0d expected 0", w_kcount);
        end
    endtask

    task automatic test_burst();
        int n;
        do_reset();
        for (int i = 0; i < 20; i++) push_byte(8'(i));
        w_enable = 1'b1;
        wait_keyreq(50, n);
        checks++;
        if (w_kcount !== KC_W'(MAX_BATCH)) begin
            errors++;
            $display("FAIL burst_kcount: got %0d expected %0d", w_kcount, MAX_BATCH);
        end
        for (int i = 0; i < MAX_BATCH; i++) pop_byte();
        w_kpop = 1'b1;
        tick();
        w_kpop = 1'b0;
        checks++;
        if (w_level !== LVL_W'(4)) begin
            errors++;
            $display("FAIL burst_extra_pop_level: got %0d expected 4", w_level);
        end
        checks++;
        if (w_kdata !== sb[0]) begin
            errors++;
            $display("FAIL burst_extra_pop_head: got %02h expected %02h", w_kdata, sb[0]);
        end
        w_kdone = 1'b1;
        tick();
        w_kdone = 1'b0;
        serve_batch(4);
        checks++;
        if (w_level !== '0) begin
            errors++;
            $display("FAIL burst_final_level: got %0d expected 0", w_level);
        end
    endtask

    task automatic test_overflow();
        int n;
        do_reset();
        for (int i = 0; i < DEPTH + 2; i++) push_byte(8'(i));
        checks++;
        if (w_rx_ready !== 1'b0 || w_overflow !== 1'b1 || w_level !== LVL_W'(DEPTH)) begin
            errors++;
            $display("FAIL ovf_full: ready=%b ovf=%b level=%0d expected 0 1 %0d",
                     w_rx_ready, w_overflow, w_level, DEPTH);
        end
        w_rx_valid = 1'b1;
        w_rx_data  = 8'hEE;
        w_ovf_clr  = 1'b1;
        tick();
        w_rx_valid = 1'b0;
        w_ovf_clr  = 1'b0;
        checks++;
        if (w_overflow !== 1'b1 || w_level !== LVL_W'(DEPTH)) begin
            errors++;
            $display("FAIL ovf_drop_beats_clr: ovf=%b level=%0d expected 1 %0d", w_overflow, w_level, DEPTH);
        end
        w_ovf_clr = 1'b1;
        tick();
        w_ovf_clr = 1'b0;
        checks++;
        if (w_overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got %b expected 0", w_overflow);
        end
        w_enable = 1'b1;
        wait_keyreq(50, n);
        checks++;
        if (w_kcount !== KC_W'(MAX_BATCH)) begin
            errors++;
            $display("FAIL ovf_kcount: got %0d expected %0d", w_kcount, MAX_BATCH);
        end
        // Pop while full: the concurrent push must still be dropped.
        checks++;
        if (w_kdata !== sb[0]) begin
            errors++;
            $display("FAIL ovf_pop_full_head: got %02h expected %02h", w_kdata, sb[0]);
        end
        w_kpop = 1'b1; w_rx_valid = 1'b1; w_rx_data = 8'hEF;
        tick();
        w_kpop = 1'b0; w_rx_valid = 1'b0;
        void'(sb.pop_front());
        checks++;
        if (w_level !== LVL_W'(DEPTH - 1) || w_overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_pop_no_rescue: level=%0d ovf=%b expected %0d 1", w_level, w_overflow, DEPTH - 1);
        end
        checks++;
        if (w_kdata !== sb[0]) begin
            errors++;
            $display("FAIL ovf_pushpop_head: got %02h expected %02h", w_kdata, sb[0]);
        end
        w_kpop = 1'b1; w_rx_valid = 1'b1; w_rx_data = 8'hF0;
        tick();
        w_kpop = 1'b0; w_rx_valid = 1'b0;
        void'(sb.pop_front());
        sb.push_back(8'hF0);
        checks++;
        if (w_level !== LVL_W'(DEPTH - 1)) begin
            errors++;
            $display("FAIL ovf_pushpop_level: got %0d expected %0d", w_level, DEPTH - 1);
        end
        for (int i = 0; i < MAX_BATCH - 2; i++) pop_byte();
        w_kdone = 1'b1;
        tick();
        w_kdone = 1'b0;
        serve_batch(16);
        serve_batch(16);
        serve_batch(16);
        serve_batch(1);
        checks++;
        if (w_level !== '0 || sb.size() != 0) begin
            errors++;
            $display("FAIL ovf_drain: level=%0d sb=%0d expected 0 0", w_level, sb.size());
        end
    endtask

    task automatic test_busy();
        int reqs;
        do_reset();
        w_enable  = 1'b1;
        w_mc_busy = 1'b1;
        for (int i = 0; i < MAX_BATCH; i++) push_byte(8'h80 + 8'(i));
        reqs = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (w_keyreq === 1'b1) reqs++;
        end
        checks++;
        if (reqs != 0 || w_level !== LVL_W'(MAX_BATCH)) begin
            errors++;
            $display("FAIL busy_hold: keyreqs=%0d level=%0d expected 0 %0d", reqs, w_level, MAX_BATCH);
        end
        w_mc_busy = 1'b0;
        tick();
        checks++;
        if (w_keyreq !== 1'b0) begin
            errors++;
            $display("FAIL busy_release_early: got %b expected 0", w_keyreq);
        end
        tick();
        checks++;
        if (w_keyreq !== 1'b1 || w_kcount !== KC_W'(MAX_BATCH)) begin
            errors++;
            $display("FAIL busy_release_req: keyreq=%b kcount=%0d expected 1 %0d", w_keyreq, w_kcount, MAX_BATCH);
        end
        for (int i = 0; i < MAX_BATCH; i++) pop_byte();
        w_kdone = 1'b1;
        tick();
        w_kdone = 1'b0;
    endtask

    task automatic test_enable_gate();
        int reqs;
        int n;
        do_reset();
        for (int i = 0; i < 3; i++) push_byte(8'hA0 + 8'(i));
        reqs = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (w_keyreq === 1'b1) reqs++;
        end
        checks++;
        if (reqs != 0 || w_level !== LVL_W'(3)) begin
            errors++;
            $display("FAIL enable_gate: keyreqs=%0d level=%0d expected 0 3", reqs, w_level);
        end
        w_enable = 1'b1;
        wait_keyreq(50, n);
        checks++;
        if (n - 1 != HOLDOFF + 1) begin
            errors++;
            $display("FAIL enable_latency: got %0d expected %0d", n - 1, HOLDOFF + 1);
        end
        checks++;
        if (w_kcount !== KC_W'(3)) begin
            errors++;
            $display("FAIL enable_kcount: got %0d expected 3", w_kcount);
        end
        for (int i = 0; i < 3; i++) pop_byte();
        w_kdone = 1'b1;
        tick();
        w_kdone = 1'b0;
    endtask

    task automatic test_reset_in_serve();
        int n;
        int reqs;
        do_reset();
        for (int i = 0; i < 5; i++) push_byte(8'hC0 + 8'(i));
        w_enable = 1'b1;
        wait_keyreq(50, n);
        checks++;
        if (w_kcount !== KC_W'(5) || w_level !== LVL_W'(5)) begin
            errors++;
            $display("FAIL rst_serve_setup: kcount=%0d level=%0d expected 5 5", w_kcount, w_level);
        end
        #2;
        RST_X = 1'b0;
        #1;
        sb.delete();
        checks++;
        if (w_level !== '0 || w_kcount !== '0 || w_keyreq !== 1'b0 || w_rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_serve_async: level=%0d kcount=%0d keyreq=%b ready=%b expected 0 0 0 1",
                     w_level, w_kcount, w_keyreq, w_rx_ready);
        end
        #1;
        RST_X = 1'b1;
        reqs = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (w_keyreq === 1'b1) reqs++;
        end
        checks++;
        if (reqs != 0 || w_level !== '0) begin
            errors++;
            $display("FAIL rst_serve_release: keyreqs=%0d level=%0d expected 0 0", reqs, w_level);
        end
    endtask

    initial begin
        RST_X      = 1'b0;
        w_rx_valid = 1'b0;
        w_rx_data  = 8'h00;
        w_enable   = 1'b0;
        w_mc_busy  = 1'b0;
        w_kpop     = 1'b0;
        w_kdone    = 1'b0;
        w_ovf_clr  = 1'b0;
        test_reset();
        test_single_byte();
        test_burst();
        test_overflow();
        test_busy();
        test_enable_gate();
        test_reset_in_serve();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
